enocoro_linear_seq: RTL and testbench

Sequencer for the nibble-serial Enocoro-128v2 linear layer L. It accepts a 16-bit byte pair {a, b} on a valid/ready port and feeds the four input nibbles to the 4-bit linear datapath over a fixed 6-cycle frame, driving the datapath's mux select. It collects the four result nibbles and presents (a⊕b, a⊕{02}·b) as one 16-bit word on a second valid/ready port. It sits between the round controller and the external nibble linear datapath, which has 4-bit data in, a mux select and 4-bit combinational data out.

---
 rtl/enocoro_linear_seq.sv | 145 ++++++++++++++
 tb/tb_enocoro_linear_seq.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enocoro_linear_seq.sv
// Sequencer for the nibble-serial Enocoro-128v2 linear layer L.
// Accepts a byte pair {a, b}. Feeds the four input nibbles to the external
// 4-bit linear datapath over a fixed six-phase frame, and collects the four
// result nibbles. Presents {a^b, a^{02}b} as one word on the output port.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | no frame in progress, datapath idles on zero input
// S_FEED | frame in progress, phase counter k_q runs 0..5
module enocoro_linear_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [3:0]  lin_din,
    output logic        lin_mux,
    input  logic [3:0]  lin_dout,
    output logic        busy,
    output logic [15:0] blocks_done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FEED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  r0_q, r0_d;
    logic [7:0]  r1_q, r1_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_data_q, out_data_d;
    logic [15:0] blocks_done_q, blocks_done_d;

    logic        accept;
    logic        frame_end;

    assign accept    = in_valid && in_ready;
    assign frame_end = (state_q == S_FEED) && (k_q == 3'd5);

    // State and datapath registers; reset discards any frame or held result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            k_q           <= 3'd0;
            a_q           <= 8'h00;
            b_q           <= 8'h00;
            r0_q          <= 8'h00;
            r1_q          <= 8'h00;
            out_valid_q   <= 1'b0;
            out_data_q    <= 16'h0000;
            blocks_done_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            a_q           <= a_d;
            b_q           <= b_d;
            r0_q          <= r0_d;
            r1_q          <= r1_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            blocks_done_q <= blocks_done_d;
        end
    end

    // Next-state logic: a frame always runs its full six phases once started.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_FEED;
            S_FEED: if (k_q == 3'd5) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Phase counter, operand latch, result capture and output buffer.
    always_comb begin
        k_d           = k_q;
        a_d           = a_q;
        b_d           = b_q;
        r0_d          = r0_q;
        r1_d          = r1_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        blocks_done_d = blocks_done_q;

        if (accept) begin
            a_d = in_data[15:8];
            b_d = in_data[7:0];
            k_d = 3'd0;
        end else if (state_q == S_FEED) begin
            k_d = frame_end ? 3'd0 : k_q + 3'd1;
            // Nibbles returned in phases 0 and 1 carry stale history; ignore them.
            case (k_q)
                3'd2:    r0_d[3:0] = lin_dout;
                3'd3:    r0_d[7:4] = lin_dout;
                3'd4:    r1_d[3:0] = lin_dout;
                3'd5:    r1_d[7:4] = lin_dout;
                default: ;
            endcase
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // The last nibble arrives on the closing edge, so take it straight
        // from lin_dout rather than from r1_q.
        if (frame_end) begin
            out_valid_d   = 1'b1;
            out_data_d    = {r0_q, lin_dout, r1_q[3:0]};
            blocks_done_d = blocks_done_q + 16'd1;
        end
    end

    // Output decode: handshake, busy flag and the datapath drive schedule.
    always_comb begin
        in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
        busy     = (state_q == S_FEED);
        lin_din  = 4'h0;
        lin_mux  = 1'b0;
        if (state_q == S_FEED) begin
            case (k_q)
                3'd0:    lin_din = a_q[3:0];
                3'd1:    lin_din = a_q[7:4];
                3'd2:    lin_din = b_q[3:0];
                3'd3:    lin_din = b_q[7:4];
                3'd4:    lin_mux = 1'b1;
                3'd5:    lin_mux = 1'b1;
                default: ;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign blocks_done = blocks_done_q;

endmodule

// File: tb/tb_enocoro_linear_seq.sv
// Testbench for enocoro_linear_seq with a behavioural nibble datapath model
// and a scoreboard of expected result words.
module tb_enocoro_linear_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [3:0]  lin_din;
    logic        lin_mux;
    logic [3:0]  lin_dout;
    logic        busy;
    logic [15:0] blocks_done;

    int checks = 0;
    int errors = 0;
    int exp_blocks = 0;

    enocoro_linear_seq dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .lin_din     (lin_din),
        .lin_mux     (lin_mux),
        .lin_dout    (lin_dout),
        .busy        (busy),
        .blocks_done (blocks_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    endfunction

    function automatic logic [15:0] lin_ref(input logic [15:0] w);
        logic [7:0] a;
        logic [7:0] b;
        a = w[15:8];
        b = w[7:0];
        return {a ^ b, a ^ gf_mul2(b)};
    endfunction

    // External datapath model: nibble history shifts while mux is 0.
    // mux=0 returns din ^ (nibble two back); mux=1 returns a^{02}b lo then hi.
    logic [3:0] h0 = 4'h0, h1 = 4'h0, h2 = 4'h0, h3 = 4'h0;
    logic       m1 = 1'b0;
    logic [7:0] dp_t;

    always @(posedge clk) begin
        if (!lin_mux) begin
            h3 <= h2;
            h2 <= h1;
            h1 <= h0;
            h0 <= lin_din;
            m1 <= 1'b0;
        end else begin
            m1 <= ~m1;
        end
    end

    always_comb begin
        dp_t = {h2, h3} ^ gf_mul2({h0, h1});
        if (lin_mux) lin_dout = m1 ? dp_t[7:4] : dp_t[3:0];
        else         lin_dout = lin_din ^ h1;
    end

    // Scoreboard monitor, sampling 1 time unit after the falling edge.
    logic [15:0] sb[$];
    logic [15:0] acc_w = 16'h0000;
    logic [15:0] prev_od = 16'h0000;
    logic [15:0] exp_w;
    logic [3:0]  ed;
    logic        em;
    logic        prev_ov = 1'b0;
    logic        prev_stall = 1'b0;
    int          cyc = 0;
    int          ph = -1;
    int          acc_cyc = -100;
    int          n_acc = 0;
    int          n_pop = 0;

    always @(negedge clk) begin
        #1;
        cyc++;
        if (reset) begin
            sb.delete();
            ph = -1;
            prev_ov = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (ph >= 0) begin
                em = (ph >= 4);
                case (ph)
                    0:       ed = acc_w[11:8];
                    1:       ed = acc_w[15:12];
                    2:       ed = acc_w[3:0];
                    3:       ed = acc_w[7:4];
                    default: ed = 4'h0;
                endcase
                checks++;
                if ({lin_din, lin_mux, busy, in_ready} !== {ed, em, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL schedule k%0d din/mux/busy/in_ready got %h/%b/%b/%b want %h/%b/1/0",
                             ph, lin_din, lin_mux, busy, in_ready, ed, em);
                end
            end else begin
                checks++;
                if ({lin_din, lin_mux, busy} !== 6'b0) begin
                    errors++;
                    $display("FAIL idle_outputs din/mux/busy got %h/%b/%b want 0/0/0",
                             lin_din, lin_mux, busy);
                end
            end

            if (out_valid && !prev_ov) begin
                checks++;
                if (cyc - acc_cyc != 7) begin
                    errors++;
                    $display("FAIL latency got %0d want 7", cyc - acc_cyc);
                end
            end
            if (prev_stall && out_valid) begin
                checks++;
                if (out_data !== prev_od) begin
                    errors++;
                    $display("FAIL stall_stable got %h want %h", out_data, prev_od);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result got %h want none", out_data);
                end else begin
                    exp_w = sb.pop_front();
                    if (out_data !== exp_w) begin
                        errors++;
                        $display("FAIL result_data got %h want %h", out_data, exp_w);
                    end
                end
                n_pop++;
            end
            prev_stall = out_valid && !out_ready;
            prev_od    = out_data;
            prev_ov    = out_valid;

            if (ph >= 0) ph = (ph == 5) ? -1 : ph + 1;
            if (in_valid && in_ready) begin
                sb.push_back(lin_ref(in_data));
                acc_w   = in_data;
                acc_cyc = cyc;
                ph      = 0;
                n_acc++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        exp_blocks = 0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit keep);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        #1;
        n = 0;
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout got in_ready=0 want 1");
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!keep) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 16'($urandom);
        end
    endtask

    task automatic wait_out(output logic [15:0] d);
        int n;
        n = 0;
        d = 16'hxxxx;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                d = out_data;
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL result_timeout got out_valid=0 want 1");
                break;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({in_ready, out_valid, out_data, busy, blocks_done, lin_din, lin_mux}
                !== {1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL %s rdy/vld/data/busy/cnt/din/mux got %b/%b/%h/%b/%h/%h/%b want 1/0/0000/0/0000/0/0",
                     tag, in_ready, out_valid, out_data, busy, blocks_done, lin_din, lin_mux);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        check_reset_values("reset_values");
    endtask

    task automatic test_basic();
        logic [15:0] d;
        out_ready = 1'b1;
        send_word(16'h1234, 0);
        wait_out(d);
        exp_blocks++;
        checks++;
        if (d !== lin_ref(16'h1234)) begin
            errors++;
            $display("FAIL basic_data got %h want %h", d, lin_ref(16'h1234));
        end
        checks++;
        if (blocks_done !== 16'(exp_blocks)) begin
            errors++;
            $display("FAIL basic_count got %h want %h", blocks_done, 16'(exp_blocks));
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_poly_wrap();
        logic [15:0] d;
        logic [15:0] words [2];
        words[0] = 16'h0080;
        words[1] = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            send_word(words[i], 0);
            wait_out(d);
            exp_blocks++;
            checks++;
            if (d !== lin_ref(words[i])) begin
                errors++;
                $display("FAIL poly_wrap_%0d got %h want %h", i, d, lin_ref(words[i]));
            end
        end
    endtask

    task automatic test_streaming();
        time t_prev;
        int  pop0;
        int  n;
        do_reset();
        out_ready = 1'b1;
        pop0   = n_pop;
        t_prev = 0;
        for (int i = 0; i < 16; i++) begin
            send_word(16'($urandom), 1);
            if (i > 0) begin
                checks++;
                if ($time - t_prev != 70) begin
                    errors++;
                    $display("FAIL stream_spacing got %0t want 70", $time - t_prev);
                end
            end
            t_prev = $time;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (n_pop < pop0 + 16 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        exp_blocks += 16;
        checks++;
        if (n_pop - pop0 != 16) begin
            errors++;
            $display("FAIL stream_results got %0d want 16", n_pop - pop0);
        end
        checks++;
        if (blocks_done !== 16'(exp_blocks)) begin
            errors++;
            $display("FAIL stream_count got %h want %h", blocks_done, 16'(exp_blocks));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [15:0] w1;
        logic [15:0] w2;
        int          acc0;
        w1 = 16'(($urandom));
        w2 = 16'(($urandom));
        @(negedge clk);
        out_ready = 1'b0;
        send_word(w1, 0);
        wait_out(d);
        checks++;
        if (d !== lin_ref(w1)) begin
            errors++;
            $display("FAIL bp_first got %h want %h", d, lin_ref(w1));
        end
        acc0 = n_acc;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w2;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if ({in_ready, busy, out_valid} !== 3'b001) begin
                errors++;
                $display("FAIL bp_hold rdy/busy/vld got %b/%b/%b want 0/0/1",
                         in_ready, busy, out_valid);
            end
            @(negedge clk);
        end
        checks++;
        if (n_acc !== acc0) begin
            errors++;
            $display("FAIL bp_no_accept got %0d want %0d", n_acc - acc0, 0);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b11) begin
            errors++;
            $display("FAIL bp_drain_accept rdy/vld got %b/%b want 1/1", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_after_edge busy/vld got %b/%b want 1/0", busy, out_valid);
        end
        wait_out(d);
        exp_blocks += 2;
        checks++;
        if (d !== lin_ref(w2)) begin
            errors++;
            $display("FAIL bp_second got %h want %h", d, lin_ref(w2));
        end
        checks++;
        if (blocks_done !== 16'(exp_blocks)) begin
            errors++;
            $display("FAIL bp_count got %h want %h", blocks_done, 16'(exp_blocks));
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] d;
        logic        seen;
        out_ready = 1'b1;
        send_word(16'h1357, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        exp_blocks = 0;
        #1;
        check_reset_values("midframe_reset_values");
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midframe_no_result got out_valid=1 want 0");
        end
        send_word(16'hA55A, 0);
        wait_out(d);
        exp_blocks++;
        checks++;
        if (d !== lin_ref(16'hA55A)) begin
            errors++;
            $display("FAIL midframe_next got %h want %h", d, lin_ref(16'hA55A));
        end
        checks++;
        if (blocks_done !== 16'(exp_blocks)) begin
            errors++;
            $display("FAIL midframe_count got %h want %h", blocks_done, 16'(exp_blocks));
        end
    endtask

    task automatic test_counter_wrap();
        logic [15:0] d;
        @(negedge clk);
        force dut.blocks_done_q = 16'hFFFF;
        @(negedge clk);
        release dut.blocks_done_q;
        #1;
        checks++;
        if (blocks_done !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload got %h want ffff", blocks_done);
        end
        send_word(16'h0F0F, 0);
        wait_out(d);
        checks++;
        if (d !== lin_ref(16'h0F0F)) begin
            errors++;
            $display("FAIL wrap_data got %h want %h", d, lin_ref(16'h0F0F));
        end
        checks++;
        if (blocks_done !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_count got %h want 0000", blocks_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_poly_wrap();
        test_streaming();
        test_back_to_back();
        test_reset_midframe();
        test_counter_wrap();
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
